lcd_bus_sequencer: RTL and testbench



---
 rtl/lcd_bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sequencer.sv
// LCD1602 8-bit write-only byte sequencer: byte FIFO plus setup/enable/hold/exec-wait timing.
// Optional power-up delay after reset is enabled by defining LCD_PWRUP_WAIT_EN.
module lcd_bus_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_SHORT_CYC = 2500,
`ifdef LCD_PWRUP_WAIT_EN
  parameter int WAIT_LONG_CYC  = 82000,
  parameter int PWRUP_CYC      = 2000000
`else
  parameter int WAIT_LONG_CYC  = 82000
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_rs,
  input  logic [7:0]                    in_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          lcd_rs,
  output logic                          lcd_rw,
  output logic                          lcd_en,
  output logic [7:0]                    lcd_data
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_TIMED = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC),
                                       max2(HOLD_CYC, WAIT_SHORT_CYC)), WAIT_LONG_CYC);
`ifdef LCD_PWRUP_WAIT_EN
  localparam int MAX_CYC = max2(MAX_TIMED, PWRUP_CYC);
`else
  localparam int MAX_CYC = MAX_TIMED;
`endif
  localparam int TW = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EN_HIGH = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_PWRUP   = 3'd5
  } state_t;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [TW-1:0]   timer;
  logic            long_cmd;
  state_t          state;
  logic            push;
  logic            pop;
  logic [CNTW-1:0] count_nxt;
  logic [8:0]      head;

  assign lcd_rw = 1'b0;
  assign head   = mem[rd_ptr];

  always_comb begin
    push      = in_valid && in_ready;
    pop       = (state == ST_IDLE) && (fifo_count != '0);
    count_nxt = fifo_count + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_rs, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= '0;
      long_cmd   <= 1'b0;
`ifdef LCD_PWRUP_WAIT_EN
      state      <= ST_PWRUP;
      timer      <= TW'(PWRUP_CYC - 1);
      busy       <= 1'b1;
`else
      state      <= ST_IDLE;
      timer      <= '0;
      busy       <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt != CNTW'(FIFO_DEPTH));
      busy       <= (fifo_count != '0) || (state != ST_IDLE);
      // lcd_en trails the state by one cycle, giving push-to-enable latency of 2+SETUP_CYC
      lcd_en     <= (state == ST_EN_HIGH);

      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            lcd_rs   <= head[8];
            lcd_data <= head[7:0];
            long_cmd <= !head[8] && (head[7:2] == '0);
            timer    <= TW'(SETUP_CYC - 1);
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer == '0) begin
            timer <= TW'(EN_HIGH_CYC - 1);
            state <= ST_EN_HIGH;
          end else timer <= timer - TW'(1);
        end
        ST_EN_HIGH: begin
          if (timer == '0) begin
            timer <= TW'(HOLD_CYC - 1);
            state <= ST_HOLD;
          end else timer <= timer - TW'(1);
        end
        ST_HOLD: begin
          if (timer == '0) begin
            timer <= long_cmd ? TW'(WAIT_LONG_CYC - 1) : TW'(WAIT_SHORT_CYC - 1);
            state <= ST_WAIT;
          end else timer <= timer - TW'(1);
        end
        ST_WAIT: begin
          if (timer == '0) state <= ST_IDLE;
          else timer <= timer - TW'(1);
        end
`ifdef LCD_PWRUP_WAIT_EN
        ST_PWRUP: begin
          if (timer == '0) state <= ST_IDLE;
          else timer <= timer - TW'(1);
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: directed vector table plus randomized traffic
// against a timeline model built from byte arrival, FIFO order and per-byte period rules.
module tb_lcd_bus_sequencer;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int E     = 3;
  localparam int H     = 2;
  localparam int WS    = 5;
  localparam int WL    = 20;
  localparam int P     = 50;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       busy;
  logic [2:0] fifo_count;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  lcd_bus_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .SETUP_CYC(S),
    .EN_HIGH_CYC(E),
    .HOLD_CYC(H),
    .WAIT_SHORT_CYC(WS),
`ifdef LCD_PWRUP_WAIT_EN
    .WAIT_LONG_CYC(WL),
    .PWRUP_CYC(P)
`else
    .WAIT_LONG_CYC(WL)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .busy(busy), .fifo_count(fifo_count),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: edge index k, queued bytes, last pop edge, earliest next pop edge
  logic [8:0] mq[$];
  int         k = 0;
  int         idle_from;
  int         last_pop;
  logic [8:0] m_out;
  bit         m_ready, m_nonidle, m_busy, m_en;

  function automatic bit is_long(input logic [8:0] b);
    return (b[8] == 1'b0) && (b[7:0] <= 8'h03);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready  = 1'b1;
    m_out    = '0;
    last_pop = -1000;
`ifdef LCD_PWRUP_WAIT_EN
    idle_from = k + P + 1;
    m_nonidle = 1'b1;
    m_busy    = 1'b1;
`else
    idle_from = k;
    m_nonidle = 1'b0;
    m_busy    = 1'b0;
`endif
  endtask

  task automatic step();
    bit push, pop;
    @(posedge clk);
    k++;
    if (reset) model_reset();
    else begin
      push   = in_valid && m_ready;
      pop    = (mq.size() != 0) && (k >= idle_from);
      m_busy = (mq.size() != 0) || m_nonidle;
      if (pop) begin
        m_out     = mq.pop_front();
        last_pop  = k;
        idle_from = k + 1 + S + E + H + (is_long(m_out) ? WL : WS);
      end
      if (push) mq.push_back({in_rs, in_data});
      m_ready   = (mq.size() != DEPTH);
      m_nonidle = (k < idle_from - 1);
    end
    m_en = (k >= last_pop + S + 1) && (k <= last_pop + S + E);
    #1;
    chk("fifo_count", fifo_count, mq.size());
    chk("in_ready", in_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("lcd_en", lcd_en, m_en);
    chk("lcd_rs", lcd_rs, m_out[8]);
    chk("lcd_data", lcd_data, m_out[7:0]);
    chk("lcd_rw", lcd_rw, 0);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    in_valid = 1'b1; in_rs = rs; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < P + 300 && (busy || fifo_count != 0); i++) step();
    chk("idle_reached", busy, 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         period;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int kp, kr, w, nr, accepted, max_cnt;
    bit saw_full, acc;
    logic prev_en;
    int rises[$];
    logic [7:0] got[$];

    vecs[0] = '{1'b0, 8'h38, 1 + S + E + H + WS};
    vecs[1] = '{1'b0, 8'h01, 1 + S + E + H + WL};
    vecs[2] = '{1'b0, 8'h02, 1 + S + E + H + WL};
    vecs[3] = '{1'b0, 8'h03, 1 + S + E + H + WL};
    vecs[4] = '{1'b0, 8'h00, 1 + S + E + H + WL};
    vecs[5] = '{1'b1, 8'h02, 1 + S + E + H + WS};
    vecs[6] = '{1'b1, 8'h01, 1 + S + E + H + WS};
    vecs[7] = '{1'b0, 8'h04, 1 + S + E + H + WS};
    vecs[8] = '{1'b1, 8'h41, 1 + S + E + H + WS};
    vecs[9] = '{1'b0, 8'h80, 1 + S + E + H + WS};

    reset = 1'b1; in_valid = 1'b0; in_rs = 1'b0; in_data = '0;
    step(); step();
    chk("reset_count", fifo_count, 0);
    chk("reset_ready", in_ready, 1);
    reset = 1'b0;
    wait_idle();

    // Single bytes into an idle block: latency, enable width, bus values, busy release
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      push_byte(vecs[i].rs, vecs[i].data);
      kp = k;
      for (int j = 0; j < 30 && !lcd_en; j++) step();
      chk("en_latency", k - kp, S + 2);
      w = 0;
      while (lcd_en && w < 30) begin
        chk("tx_rs", lcd_rs, vecs[i].rs);
        chk("tx_data", lcd_data, vecs[i].data);
        step();
        w++;
      end
      chk("en_width", w, E);
      for (int j = 0; j < 100 && busy; j++) step();
      chk("busy_fall", k - (kp + 1), vecs[i].period);
    end

    // Back-to-back: long command then data then command
    wait_idle();
    in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h01; step();
    in_rs = 1'b1; in_data = 8'h41; step();
    in_rs = 1'b0; in_data = 8'h38; step();
    in_valid = 1'b0;
    prev_en = lcd_en;
    for (int j = 0; j < 200 && rises.size() < 3; j++) begin
      step();
      if (lcd_en && !prev_en) rises.push_back(k);
      prev_en = lcd_en;
    end
    chk("b2b_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("period_long", rises[1] - rises[0], 1 + S + E + H + WL);
      chk("period_short", rises[2] - rises[1], 1 + S + E + H + WS);
    end

    // Continuous producer overrunning the FIFO
    wait_idle();
    accepted = 0; max_cnt = 0; saw_full = 1'b0; prev_en = lcd_en;
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hA0;
    for (int j = 0; j < 2000 && !(accepted == 6 && !busy); j++) begin
      acc = in_ready && in_valid;
      step();
      if (acc) begin
        accepted++;
        if (accepted < 6) in_data = 8'(8'hA0 + accepted);
        else in_valid = 1'b0;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = fifo_count;
      if (!in_ready) saw_full = 1'b1;
      if (lcd_en && !prev_en) got.push_back(lcd_data);
      prev_en = lcd_en;
    end
    in_valid = 1'b0;
    chk("fill_max_count", max_cnt, DEPTH);
    chk("fill_saw_full", saw_full, 1);
    chk("fill_accepted", accepted, 6);
    chk("fill_out_count", got.size(), 6);
    foreach (got[i]) chk("fill_order", got[i], 8'hA0 + i);

    // Randomized traffic, biased towards the long-command codes
    for (int j = 0; j < 600; j++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_rs    = 1'($urandom_range(0, 1));
      in_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step();
    end
    in_valid = 1'b0;

    // Reset while the second byte has lcd_en high, with a third byte still queued
    wait_idle();
    in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h0C; step();
    in_rs = 1'b1; in_data = 8'h48; step();
    in_rs = 1'b1; in_data = 8'h49; step();
    in_valid = 1'b0;
    nr = 0; prev_en = lcd_en;
    for (int j = 0; j < 200 && nr < 2; j++) begin
      step();
      if (lcd_en && !prev_en) nr++;
      prev_en = lcd_en;
    end
    chk("rst_second_en", nr, 2);
    chk("rst_pre_count", fifo_count, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_en", lcd_en, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", in_ready, 1);
    wait_idle();
    push_byte(1'b1, 8'h55);
    kp = k;
    for (int j = 0; j < 30 && !lcd_en; j++) step();
    chk("rst_after_latency", k - kp, S + 2);
    chk("rst_after_data", lcd_data, 8'h55);
    wait_idle();

`ifdef LCD_PWRUP_WAIT_EN
    reset = 1'b1;
    step();
    kr = k;
    reset = 1'b0;
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_valid = 1'b0;
    step(); step();
    chk("pwrup_count", fifo_count, 2);
    chk("pwrup_busy", busy, 1);
    for (int j = 0; j < P + 60 && !lcd_en; j++) step();
    chk("pwrup_first_en_min", (k - kr >= P + 1 + S), 1);
    chk("pwrup_first_data", lcd_data, 8'h31);
    wait_idle();
`else
    kr = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
